// File: rtl/gpio_walk_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : gpio_walk_gen_if
// Purpose  : Control/pad bundle between the walking-one pattern source and the
//            logic that drives and observes it (enable, start, frame setup,
//            pad data/output-enable and status).
// Revision : 1.0 - initial release
// ============================================================================
interface gpio_walk_gen_if #(
  parameter int NBITS   = 34,
  parameter int DWELL_W = 24,
  parameter int ITER_W  = 8
);
  logic               en_i;
  logic               start_i;
  logic [DWELL_W-1:0] dwell_i;
  logic [ITER_W-1:0]  iters_i;
  logic [NBITS+3:0]   io_out;
  logic [NBITS+3:0]   io_oeb;
  logic               busy_o;
  logic               done_o;
  logic [5:0]         frame_o;

  // Side that requests walks and watches the pads
  modport master (
    output en_i, start_i, dwell_i, iters_i,
    input  io_out, io_oeb, busy_o, done_o, frame_o
  );

  // Pattern source side
  modport slave (
    input  en_i, start_i, dwell_i, iters_i,
    output io_out, io_oeb, busy_o, done_o, frame_o
  );
endinterface
`default_nettype wire

// File: rtl/gpio_walk_gen.sv
`default_nettype none
// ============================================================================
// Module   : gpio_walk_gen
// Purpose  : Framed walking-one generator for the checked GPIO pads
//            {io[37:5], io[0]}: zero frame, NBITS one-hot frames LSB first,
//            repeated N times with a zero frame between walks, then a final
//            zero frame. Every frame is held D cycles.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_walk_gen #(
  parameter int NBITS   = 34,
  parameter int DWELL_W = 24,
  parameter int ITER_W  = 8
) (
  input  wire logic       wb_clk_i,
  input  wire logic       wb_rst_i,
  gpio_walk_gen_if.slave  bus
);

  localparam int IDX_W = 6;
  localparam int IO_W  = NBITS + 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEAD_Z = 3'd1,
    S_WALK   = 3'd2,
    S_GAP_Z  = 3'd3,
    S_TAIL_Z = 3'd4
  } state_t;

  state_t             r_state, w_state;
  logic [DWELL_W-1:0] r_cnt, w_cnt;      // cycles left in current frame, minus one
  logic [DWELL_W-1:0] r_dm1, w_dm1;      // latched dwell minus one (dwell 0 acts as 1)
  logic [ITER_W-1:0]  r_iters, w_iters;  // latched iteration count
  logic [ITER_W-1:0]  r_iter, w_iter;    // completed walks
  logic [IDX_W-1:0]   r_idx, w_idx;      // one-hot position within a walk
  logic               w_done;
  logic               w_busy;
  logic [IDX_W-1:0]   w_frame_o;
  logic [NBITS-1:0]   w_onehot;
  logic [IO_W-1:0]    w_io_out;
  logic [IO_W-1:0]    w_io_oeb;
  logic [ITER_W:0]    w_iter_inc;
  logic               w_cnt_zero;

  logic [IO_W-1:0]    r_io_out;
  logic [IO_W-1:0]    r_io_oeb;
  logic               r_busy;
  logic               r_done;
  logic [IDX_W-1:0]   r_frame_o;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_iter_inc = {1'b0, r_iter} + (ITER_W+1)'(1);

  // State, counters and registered outputs; reset returns everything to idle
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_dm1     <= '0;
      r_iters   <= '0;
      r_iter    <= '0;
      r_idx     <= '0;
      r_io_out  <= '0;
      r_io_oeb  <= '1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_frame_o <= '0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_dm1     <= w_dm1;
      r_iters   <= w_iters;
      r_iter    <= w_iter;
      r_idx     <= w_idx;
      r_io_out  <= w_io_out;
      r_io_oeb  <= w_io_oeb;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_frame_o <= w_frame_o;
    end
  end

  // Next-state logic; output values are those of the state being entered so
  // the pads change on the same edge as the state
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_dm1   = r_dm1;
    w_iters = r_iters;
    w_iter  = r_iter;
    w_idx   = r_idx;
    w_done  = 1'b0;

    if (!bus.en_i) begin
      // Disable aborts any walk without a done pulse
      w_state = S_IDLE;
      w_cnt   = '0;
      w_iter  = '0;
      w_idx   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            w_dm1   = (bus.dwell_i == '0) ? '0 : bus.dwell_i - DWELL_W'(1);
            w_cnt   = w_dm1;
            w_iters = bus.iters_i;
            w_iter  = '0;
            w_idx   = '0;
            w_state = S_LEAD_Z;
          end
        end
        S_LEAD_Z: begin
          if (w_cnt_zero) begin
            w_cnt   = r_dm1;
            w_idx   = '0;
            w_state = (r_iters == '0) ? S_TAIL_Z : S_WALK;
          end else begin
            w_cnt = r_cnt - DWELL_W'(1);
          end
        end
        S_WALK: begin
          if (w_cnt_zero) begin
            w_cnt = r_dm1;
            if (r_idx == IDX_W'(NBITS - 1)) begin
              w_iter  = w_iter_inc[ITER_W-1:0];
              w_idx   = '0;
              w_state = (w_iter_inc < {1'b0, r_iters}) ? S_GAP_Z : S_TAIL_Z;
            end else begin
              w_idx = r_idx + IDX_W'(1);
            end
          end else begin
            w_cnt = r_cnt - DWELL_W'(1);
          end
        end
        S_GAP_Z: begin
          if (w_cnt_zero) begin
            w_cnt   = r_dm1;
            w_idx   = '0;
            w_state = S_WALK;
          end else begin
            w_cnt = r_cnt - DWELL_W'(1);
          end
        end
        S_TAIL_Z: begin
          if (w_cnt_zero) begin
            w_cnt   = '0;
            w_done  = 1'b1;
            w_state = S_IDLE;
          end else begin
            w_cnt = r_cnt - DWELL_W'(1);
          end
        end
        default: begin
          w_state = S_IDLE;
          w_cnt   = '0;
          w_idx   = '0;
        end
      endcase
    end
  end

  // Output decode for the state being entered
  always_comb begin
    w_busy    = (w_state != S_IDLE);
    w_frame_o = (w_state == S_WALK) ? w_idx : '0;
    w_onehot  = (w_state == S_WALK) ? ({{(NBITS-1){1'b0}}, 1'b1} << w_idx) : '0;
    // io[4:1] are not checked pads: always driven low with output disabled
    w_io_out  = {w_onehot[NBITS-1:1], 4'b0000, w_onehot[0]};
    w_io_oeb  = {{(NBITS-1){~bus.en_i}}, 4'b1111, ~bus.en_i};
  end

  assign bus.io_out  = r_io_out;
  assign bus.io_oeb  = r_io_oeb;
  assign bus.busy_o  = r_busy;
  assign bus.done_o  = r_done;
  assign bus.frame_o = r_frame_o;

endmodule
`default_nettype wire

// File: tb/tb_gpio_walk_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_walk_gen
// Purpose  : Self-checking bench for gpio_walk_gen: table-driven walks,
//            randomized walks against a frame-list model, and hand-written
//            abort / reset / restart / long-dwell sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_walk_gen;
  localparam int NBITS   = 34;
  localparam int DWELL_W = 24;
  localparam int ITER_W  = 8;
  localparam int IO_W    = 38;
  localparam logic [IO_W-1:0] OEB_ON  = 38'h00_0000_001E;
  localparam logic [IO_W-1:0] OEB_OFF = 38'h3F_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gpio_walk_gen_if #(.NBITS(NBITS), .DWELL_W(DWELL_W), .ITER_W(ITER_W)) bus ();

  gpio_walk_gen #(.NBITS(NBITS), .DWELL_W(DWELL_W), .ITER_W(ITER_W)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [IO_W-1:0] io;
    logic [IO_W-1:0] oeb;
    logic            busy;
    logic            done;
    logic [5:0]      fo;
  } obs_t;

  typedef struct {
    int dwell;
    int iters;
    int exp_busy;
    int exp_done;
  } vec_t;

  obs_t exp_q[$];

  function automatic obs_t mk(logic [IO_W-1:0] io, logic [IO_W-1:0] oeb,
                              logic busy, logic done, int fo);
    obs_t o;
    o.io = io; o.oeb = oeb; o.busy = busy; o.done = done; o.fo = 6'(fo);
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(bus.io_out, bus.io_oeb, bus.busy_o, bus.done_o, int'(bus.frame_o));
  endfunction

  // Checked-frame bit k sits on pad 0 for k==0, pad k+4 otherwise
  function automatic logic [IO_W-1:0] pads(logic [NBITS-1:0] f);
    logic [IO_W-1:0] p;
    p = '0;
    for (int k = 0; k < NBITS; k++) p[(k == 0) ? 0 : k + 4] = f[k];
    return p;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t req, output bit ok);
    checks++;
    ok = (act === req);
    if (!ok) begin
      errors++;
      $display("FAIL %s: got io=%h oeb=%h busy=%b done=%b frame=%0d, want io=%h oeb=%h busy=%b done=%b frame=%0d",
               name, act.io, act.oeb, act.busy, act.done, act.fo,
               req.io, req.oeb, req.busy, req.done, req.fo);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // Model: list of frames, each repeated D times, then done and idle cycles
  task automatic push_frame(input logic [NBITS-1:0] f, input int fo, input int d);
    repeat (d) exp_q.push_back(mk(pads(f), OEB_ON, 1'b1, 1'b0, fo));
  endtask

  task automatic build_model(input int dwell, input int iters);
    int d;
    d = (dwell == 0) ? 1 : dwell;
    exp_q.delete();
    push_frame('0, 0, d);
    for (int it = 0; it < iters; it++) begin
      if (it > 0) push_frame('0, 0, d);
      for (int b = 0; b < NBITS; b++) push_frame(NBITS'(1) << b, b, d);
    end
    push_frame('0, 0, d);
    exp_q.push_back(mk('0, OEB_ON, 1'b0, 1'b1, 0));
    exp_q.push_back(mk('0, OEB_ON, 1'b0, 1'b0, 0));
  endtask

  task automatic apply_reset(input logic en);
    bus.start_i = 1'b0;
    bus.en_i    = en;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Starts a walk and compares every cycle against the model; optionally
  // re-pulses start with new settings while frame 1<<20 is showing
  task automatic run_seq(input string name, input int dwell, input int iters, input bit poke,
                         output int busy_len, output int done_cnt);
    obs_t a;
    bit   ok;
    bit   poked;
    poked    = 1'b0;
    busy_len = 0;
    done_cnt = 0;
    build_model(dwell, iters);
    bus.dwell_i = DWELL_W'(dwell);
    bus.iters_i = ITER_W'(iters);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    foreach (exp_q[i]) begin
      a = sample();
      busy_len += int'(a.busy);
      done_cnt += int'(a.done);
      check(name, a, exp_q[i], ok);
      if (!ok) break;
      if (poke && !poked && exp_q[i].fo == 6'd20) begin
        bus.start_i = 1'b1;
        bus.dwell_i = DWELL_W'(9);
        bus.iters_i = ITER_W'(3);
        poked = 1'b1;
      end
      @(negedge clk);
      bus.start_i = 1'b0;
    end
  endtask

  // Starts a dwell=1 single walk and waits (bounded) for frame 1<<12
  task automatic start_and_wait12(input string name);
    int n;
    bus.dwell_i = DWELL_W'(1);
    bus.iters_i = ITER_W'(1);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    n = 0;
    while (!(bus.busy_o && bus.frame_o == 6'd12) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_int({name, "_reach12"}, int'(bus.frame_o), 12);
  endtask

  vec_t vecs[7];

  initial begin
    int   bl, dc, d, n, cnt;
    bit   ok;
    obs_t a;

    vecs[0] = '{1, 2, 71, 1};
    vecs[1] = '{5, 1, 180, 1};
    vecs[2] = '{0, 1, 36, 1};
    vecs[3] = '{1, 1, 36, 1};
    vecs[4] = '{0, 0, 2, 1};
    vecs[5] = '{3, 0, 6, 1};
    vecs[6] = '{2, 3, 212, 1};

    rst = 1'b1;
    bus.en_i = 1'b0; bus.start_i = 1'b0; bus.dwell_i = '0; bus.iters_i = '0;
    @(negedge clk);
    check("reset_values", sample(), mk('0, OEB_OFF, 1'b0, 1'b0, 0), ok);
    rst = 1'b0;

    // Disabled: start ignored, pads stay inputs
    @(negedge clk);
    bus.dwell_i = DWELL_W'(1); bus.iters_i = ITER_W'(1); bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("disabled_idle", sample(), mk('0, OEB_OFF, 1'b0, 1'b0, 0), ok);
      if (!ok) break;
      @(negedge clk);
    end
    bus.en_i = 1'b1;
    @(negedge clk);
    check("enable_oeb", sample(), mk('0, OEB_ON, 1'b0, 1'b0, 0), ok);

    // Table-driven walks
    for (int v = 0; v < 7; v++) begin
      apply_reset(1'b1);
      run_seq($sformatf("vec%0d_trace", v), vecs[v].dwell, vecs[v].iters, 1'b0, bl, dc);
      check_int($sformatf("vec%0d_busy_len", v), bl, vecs[v].exp_busy);
      check_int($sformatf("vec%0d_done_cnt", v), dc, vecs[v].exp_done);
    end

    // Randomized walks against the model and the closed-form busy length
    for (int r = 0; r < 6; r++) begin
      d = int'($urandom_range(0, 6));
      n = int'($urandom_range(0, 3));
      apply_reset(1'b1);
      run_seq($sformatf("rand%0d_trace_d%0d_n%0d", r, d, n), d, n, 1'b0, bl, dc);
      if (d == 0) d = 1;
      check_int($sformatf("rand%0d_busy_len", r), bl, (n == 0) ? 2 * d : d * (1 + n * (NBITS + 1)));
      check_int($sformatf("rand%0d_done_cnt", r), dc, 1);
    end

    // Start re-pulsed mid-walk with different settings has no effect
    apply_reset(1'b1);
    run_seq("restart_ignored_trace", 2, 1, 1'b1, bl, dc);
    check_int("restart_ignored_busy_len", bl, 72);

    // Enable dropped at frame 1<<12
    apply_reset(1'b1);
    start_and_wait12("en_drop");
    bus.en_i = 1'b0;
    @(negedge clk);
    check("en_drop_abort", sample(), mk('0, OEB_OFF, 1'b0, 1'b0, 0), ok);
    bus.en_i = 1'b1;
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      cnt += int'(bus.done_o) + int'(bus.busy_o);
    end
    check_int("en_drop_no_done_no_busy", cnt, 0);

    // Asynchronous reset mid-walk
    start_and_wait12("rst_pulse");
    rst = 1'b1;
    #1;
    check("rst_async_values", sample(), mk('0, OEB_OFF, 1'b0, 1'b0, 0), ok);
    @(negedge clk);
    rst = 1'b0;

    // Maximum dwell must not wrap to a short frame
    apply_reset(1'b1);
    bus.dwell_i = '1; bus.iters_i = ITER_W'(1); bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      a = sample();
      check("max_dwell_lead_hold", a, mk('0, OEB_ON, 1'b1, 1'b0, 0), ok);
      if (!ok) break;
      checks--;
      @(negedge clk);
    end
    checks++;
    apply_reset(1'b1);
    check("after_max_dwell_reset", sample(), mk('0, OEB_ON, 1'b0, 1'b0, 0), ok);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
